// File: rtl/lsu_mem_responder.sv
// Load/store responder: word-addressed backing memory with a fixed-latency
// response pipeline feeding an in-order response FIFO.
module lsu_mem_responder #(
    parameter int LATENCY      = 2,
    parameter int RESP_DEPTH   = 4,
    parameter int MEM_WORDS    = 256,
    parameter int ROB_ID_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_ld_st,
    input  logic [1:0]              req_width,
    input  logic                    req_sign_ext,
    input  logic [31:0]             req_addr,
    input  logic [31:0]             req_st_data,
    input  logic [ROB_ID_WIDTH-1:0] req_rob_id,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ROB_ID_WIDTH-1:0] resp_rob_id,
    output logic                    resp_is_st,
    output logic [31:0]             resp_data,
    output logic                    resp_err
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    typedef struct packed {
        logic                    valid;
        logic [ROB_ID_WIDTH-1:0] rob_id;
        logic                    is_st;
        logic                    err;
        logic [31:0]             data;
    } resp_t;

    logic [31:0]   mem [MEM_WORDS];
    resp_t         pipe [LATENCY];
    resp_t         fifo [RESP_DEPTH];
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          accept;
    logic          push;
    logic          pop;
    logic          misaligned;
    logic [AW-1:0] widx;
    logic [31:0]   rword;
    logic [31:0]   shifted;
    logic [31:0]   ld_data;
    logic [31:0]   wdata;
    logic [3:0]    be;
    resp_t         entry;
    resp_t         head;
    logic          unused_bits;

    // Readiness depends only on reset and the registered outstanding count.
    assign req_ready  = !rst && (outstanding < CW'(RESP_DEPTH));
    assign accept     = req_valid && req_ready;
    assign resp_valid = !rst && (fifo_count != '0);
    assign pop        = resp_valid && resp_ready;
    assign push       = pipe[LATENCY-1].valid;

    // Upper address bits wrap onto the memory.
    assign widx    = req_addr[AW+1:2];
    assign rword   = mem[widx];
    assign shifted = rword >> {req_addr[1:0], 3'b000};
    assign head    = fifo[rd_ptr];

    assign unused_bits = ^{req_addr[31:AW+2], head.valid};

    // Decode width into byte enables, lane data and the load result.
    always_comb begin
        misaligned = 1'b0;
        be         = 4'b0000;
        wdata      = req_st_data;
        ld_data    = rword;
        case (req_width)
            2'b00: begin
                be      = 4'b0001 << req_addr[1:0];
                wdata   = {4{req_st_data[7:0]}};
                ld_data = {{24{req_sign_ext & shifted[7]}},
                           shifted[7:0]};
            end
            2'b01: begin
                misaligned = req_addr[0];
                be         = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{req_st_data[15:0]}};
                ld_data    = {{16{req_sign_ext & shifted[15]}},
                              shifted[15:0]};
            end
            default: begin
                misaligned = (req_addr[1:0] != 2'b00);
                be         = 4'b1111;
            end
        endcase
        entry.valid  = accept;
        entry.rob_id = req_rob_id;
        entry.is_st  = req_ld_st;
        entry.err    = misaligned;
        entry.data   = (req_ld_st || misaligned) ? 32'h0 : ld_data;
    end

    // Aligned stores write their lanes on the acceptance edge; reset leaves memory alone.
    always_ff @(posedge clk) begin
        if (accept && req_ld_st && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Fixed-latency response pipeline; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) pipe[i].valid <= 1'b0;
        end else begin
            pipe[0] <= entry;
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    // FIFO storage, written as responses leave the pipeline.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= pipe[LATENCY-1];
    end

    // Pointers and occupancy counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(RESP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(RESP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            fifo_count  <= fifo_count + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(accept) - CW'(pop);
        end
    end

    assign resp_rob_id = resp_valid ? head.rob_id : '0;
    assign resp_is_st  = resp_valid ? head.is_st : 1'b0;
    assign resp_err    = resp_valid ? head.err : 1'b0;
    assign resp_data   = resp_valid ? head.data : 32'h0;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Scoreboard bench for lsu_mem_responder: directed loads/stores,
// misalignment, wrap, backpressure, latency and mid-flight reset.
module tb_lsu_mem_responder;

    typedef struct packed {
        logic [4:0]  rob;
        logic        is_st;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_ld_st;
    logic [1:0]  req_width;
    logic        req_sign_ext;
    logic [31:0] req_addr;
    logic [31:0] req_st_data;
    logic [4:0]  req_rob_id;
    logic        resp_valid;
    logic        resp_ready;
    logic [4:0]  resp_rob_id;
    logic        resp_is_st;
    logic [31:0] resp_data;
    logic        resp_err;

    int checks = 0;
    int fails  = 0;
    exp_t sbq[$];

    lsu_mem_responder dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_ld_st    (req_ld_st),
        .req_width    (req_width),
        .req_sign_ext (req_sign_ext),
        .req_addr     (req_addr),
        .req_st_data  (req_st_data),
        .req_rob_id   (req_rob_id),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rob_id  (resp_rob_id),
        .resp_is_st   (resp_is_st),
        .resp_data    (resp_data),
        .resp_err     (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: values sampled at the edge are the pre-edge values.
    always @(posedge clk) begin
        if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL resp_unexpected: got rob %0d, none expected",
                         resp_rob_id);
            end else begin
                exp_t e;
                exp_t g;
                e = sbq.pop_front();
                g = '{resp_rob_id, resp_is_st, resp_err, resp_data};
                checks++;
                if (g !== e) begin
                    fails++;
                    $display("FAIL resp: got rob %0d st %b err %b data %h expected rob %0d st %b err %b data %h",
                             g.rob, g.is_st, g.err, g.data,
                             e.rob, e.is_st, e.err, e.data);
                end
            end
        end
    end

    task automatic send(input logic st, input logic [1:0] w,
                        input logic sx, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] id,
                        input exp_t e, input bit push);
        int n;
        req_ld_st    = st;
        req_width    = w;
        req_sign_ext = sx;
        req_addr     = a;
        req_st_data  = d;
        req_rob_id   = id;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("send_timeout", 32'(req_ready), 32'd1);
        else if (push) sbq.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sbq.size()), 32'd0);
    endtask

    task automatic load(input logic [1:0] w, input logic sx,
                        input logic [31:0] a, input logic [4:0] id,
                        input logic [31:0] data, input logic err);
        send(1'b0, w, sx, a, 32'h0, id, '{id, 1'b0, err, data}, 1'b1);
    endtask

    task automatic store(input logic [1:0] w, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] id,
                         input logic err);
        send(1'b1, w, 1'b0, a, d, id, '{id, 1'b1, err, 32'h0}, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bool_t_dummy: begin end
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_ld_st    = 1'b0;
        req_width    = 2'b10;
        req_sign_ext = 1'b0;
        req_addr     = 32'h0;
        req_st_data  = 32'h0;
        req_rob_id   = 5'd0;
        resp_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_outputs", {resp_rob_id, resp_is_st, resp_err},
            32'd0);
        chk("rst_resp_data", resp_data, 32'h0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        @(negedge clk);
        resp_ready = 1'b1;

        store(2'b10, 32'h10, 32'hDEADBEEF, 5'd3, 1'b0);
        load(2'b00, 1'b1, 32'h13, 5'd4, 32'hFFFFFFDE, 1'b0);
        load(2'b01, 1'b0, 32'h12, 5'd5, 32'h0000DEAD, 1'b0);
        load(2'b00, 1'b0, 32'h10, 5'd6, 32'h000000EF, 1'b0);
        load(2'b01, 1'b1, 32'h10, 5'd7, 32'hFFFFBEEF, 1'b0);
        store(2'b00, 32'h11, 32'hAAAAAA55, 5'd8, 1'b0);
        load(2'b10, 1'b0, 32'h10, 5'd9, 32'hDEAD55EF, 1'b0);
        store(2'b01, 32'h12, 32'hFFFF1234, 5'd10, 1'b0);
        load(2'b10, 1'b0, 32'h10, 5'd11, 32'h123455EF, 1'b0);

        load(2'b01, 1'b1, 32'h11, 5'd12, 32'h0, 1'b1);
        store(2'b10, 32'h12, 32'hFFFFFFFF, 5'd13, 1'b1);
        load(2'b10, 1'b0, 32'h10, 5'd14, 32'h123455EF, 1'b0);
        load(2'b11, 1'b0, 32'h10, 5'd15, 32'h123455EF, 1'b0);

        store(2'b10, 32'h410, 32'hCAFEF00D, 5'd16, 1'b0);
        load(2'b10, 1'b0, 32'h010, 5'd17, 32'hCAFEF00D, 1'b0);
        drain();

        req_ld_st    = 1'b0;
        req_width    = 2'b10;
        req_sign_ext = 1'b0;
        req_addr     = 32'h10;
        req_rob_id   = 5'd18;
        req_valid    = 1'b1;
        chk("lat_ready", 32'(req_ready), 32'd1);
        sbq.push_back('{5'd18, 1'b0, 1'b0, 32'hCAFEF00D});
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("lat_n0", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1 chk("lat_n1", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1 chk("lat_n2", 32'(resp_valid), 32'd1);
        @(posedge clk);
        #1 chk("lat_n3", 32'(resp_valid), 32'd0);
        @(negedge clk);
        drain();

        resp_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            req_ld_st  = 1'b0;
            req_width  = 2'b10;
            req_addr   = 32'h10;
            req_rob_id = 5'(20 + k);
            req_valid  = 1'b1;
            if (req_ready) begin
                sbq.push_back('{5'(20 + k), 1'b0, 1'b0, 32'hCAFEF00D});
                k++;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("bp_accepted", 32'(k), 32'd4);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        chk("hold_rob_a", 32'(resp_rob_id), 32'd20);
        repeat (2) @(negedge clk);
        chk("hold_rob_b", 32'(resp_rob_id), 32'd20);
        chk("hold_data", resp_data, 32'hCAFEF00D);
        chk("hold_valid", 32'(resp_valid), 32'd1);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp_ready_back", 32'(req_ready), 32'd1);
        sbq.push_back('{5'd24, 1'b0, 1'b0, 32'hCAFEF00D});
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_fifth_taken", 32'(req_ready), 32'd0);
        resp_ready = 1'b1;
        drain();

        resp_ready = 1'b0;
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd25, '0, 1'b0);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd26, '0, 1'b0);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd27, '0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_data", resp_data, 32'h0);
        rst = 1'b0;
        resp_ready = 1'b1;
        #1 chk("post_rst_ready", 32'(req_ready), 32'd1);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) k++;
        end
        chk("post_rst_no_resp", 32'(k), 32'd0);
        load(2'b10, 1'b0, 32'h10, 5'd30, 32'hCAFEF00D, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
